// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter
// Brief    : ALU with registered result; single-cycle ops plus optional
//            iterative radix-2 shift-add multiply (enable macro ALU_ITER_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_ITER_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [5:0] CNT_LAST = 6'(DATA_W - 1);
`endif

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_SGT  = 4'b1100;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              accept;
    logic              is_mul;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] result;
    logic              zero;

`ifdef ALU_ITER_MUL_EN
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [5:0]        count;
    logic              mul_last;

    assign is_mul   = (ctrl_i == OP_MUL);
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (state == S_MUL) && (count == CNT_LAST);
`else
    assign is_mul = 1'b0;
`endif

    // Starts arriving while a multiply runs are dropped, not queued.
    assign accept = start_i && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (src1_i < src2_i)};
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SUB,
            OP_BEQ:  alu_res = src1_i - src2_i;
            OP_SRA:  alu_res = $signed(src2_i) >>> shamt_i;
            OP_SRAV: alu_res = $signed(src2_i) >>> src1_i[4:0];
            OP_LUI:  alu_res = src2_i << 16;
            OP_SGT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) > $signed(src2_i))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE,
            S_DONE: begin
                if (start_i) begin
`ifdef ALU_ITER_MUL_EN
                    state_nxt = is_mul ? S_MUL : S_DONE;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_IDLE;
                end
            end
`ifdef ALU_ITER_MUL_EN
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
`ifdef ALU_ITER_MUL_EN
        busy = (state == S_MUL);
`endif
        done = (state == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result <= '0;
            zero   <= 1'b1;
`ifdef ALU_ITER_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
`endif
        end else begin
            if (accept) begin
`ifdef ALU_ITER_MUL_EN
                count <= '0;
                if (is_mul) begin
                    mcand  <= src1_i;
                    mplier <= src2_i;
                    acc    <= '0;
                end else begin
`else
                if (!is_mul) begin
`endif
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                end
            end
`ifdef ALU_ITER_MUL_EN
            else if (state == S_MUL) begin
                // One shift-add step per cycle; the last step lands straight in result.
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 6'd1;
                if (count == CNT_LAST) begin
                    result <= acc_nxt;
                    zero   <= (acc_nxt == '0);
                end
            end
`endif
        end
    end

    assign result_o = result;
    assign zero_o   = zero;
    assign busy_o   = busy;
    assign done_o   = done;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iter
// Brief    : Directed self-checking bench for alu_iter (both macro builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  ctrl_i = 4'd0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [31:0] result_o;
    logic        zero_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    logic busy_seen = 1'b0;

    alu_iter #(.DATA_W(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (busy_o === 1'b1) busy_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one request for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge clk_i);
        start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp, input logic expz);
        issue(c, a, b, sh);
        src1_i = 32'hDEAD_BEEF; src2_i = 32'h1357_9BDF;
        check({tag, "_res"}, result_o, exp);
        check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, expz});
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        int cyc;
        int busy_n;
        int done_at;
        logic held_bad;
        logic done_seen;

        // Reset values while rst_i is held low
        #12;
        check("rst_res", result_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("idle_done", {31'd0, done_o}, 32'd0);

        single("add", 4'b0010, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);
        @(posedge clk_i); #1;
        check("add_done_pulse", {31'd0, done_o}, 32'd0);
        check("add_hold_idle", result_o, 32'd12);
        repeat (3) @(posedge clk_i); #1;
        check("add_hold_idle3", result_o, 32'd12);

        single("beq",  4'b0111, 32'd9, 32'd9, 5'd0, 32'd0, 1'b1);
        single("slt",  4'b0100, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
        single("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1);
        single("sgt",  4'b1100, 32'd2, 32'hFFFF_FFFE, 5'd0, 32'd1, 1'b0);
        single("sra",  4'b1000, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
        single("srav", 4'b1001, 32'd8, 32'h8000_0000, 5'd0, 32'hFF80_0000, 1'b0);
        single("lui",  4'b1011, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0);
        single("and",  4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0);
        single("or",   4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0, 1'b0);
        single("sub",  4'b0110, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0);
        single("addw", 4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1);
        single("unl",  4'b1111, 32'd4, 32'd4, 5'd0, 32'd0, 1'b1);
        single("pre",  4'b0010, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);
        single("unl2", 4'b1010, 32'd4, 32'd4, 5'd0, 32'd0, 1'b1);

        // Start held high through DONE issues the next op back-to-back
        @(negedge clk_i);
        start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd5; src2_i = 32'd7;
        @(posedge clk_i); #1;
        src1_i = 32'd1; src2_i = 32'd2;
        check("b2b_first", result_o, 32'd12);
        check("b2b_first_done", {31'd0, done_o}, 32'd1);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("b2b_second", result_o, 32'd3);
        check("b2b_second_done", {31'd0, done_o}, 32'd1);
        @(posedge clk_i); #1;
        check("b2b_idle", {31'd0, done_o}, 32'd0);

`ifdef ALU_ITER_MUL_EN
        // Multiply with an ignored add request partway through
        issue(4'b0101, 32'hFFFF_FFFF, 32'd3, 5'd0);
        cyc = 1; busy_n = 0; done_at = 0; held_bad = 1'b0;
        while (done_at == 0 && cyc < 60) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_at = cyc;
            end else begin
                if (result_o !== 32'd3) held_bad = 1'b1;
                if (cyc == 10) begin
                    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1;
                end else begin
                    start_i = 1'b0;
                end
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        start_i = 1'b0;
        check("mul_done_cycle", done_at, 32'd33);
        check("mul_busy_cycles", busy_n, 32'd32);
        check("mul_hold", {31'd0, held_bad}, 32'd0);
        check("mul_res", result_o, 32'hFFFF_FFFD);
        check("mul_zero", {31'd0, zero_o}, 32'd0);
        @(posedge clk_i); #1;
        check("mul_noqueue_done", {31'd0, done_o}, 32'd0);
        check("mul_noqueue_res", result_o, 32'hFFFF_FFFD);

        issue(4'b0101, 32'd6, 32'd7, 5'd0);
        cyc = 1;
        while (!done_o && cyc < 60) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        check("mul67_cycle", cyc, 32'd33);
        check("mul67_res", result_o, 32'd42);
`else
        issue(4'b0101, 32'd6, 32'd7, 5'd0);
        check("mul_off_res", result_o, 32'd0);
        check("mul_off_zero", {31'd0, zero_o}, 32'd1);
        check("mul_off_done", {31'd0, done_o}, 32'd1);
        check("mul_off_busy", {31'd0, busy_o}, 32'd0);
`endif

        // Reset asserted mid-operation
        single("premul", 4'b0010, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0);
        issue(4'b0101, 32'd6, 32'd7, 5'd0);
        repeat (14) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("mrst_res", result_o, 32'd0);
        check("mrst_zero", {31'd0, zero_o}, 32'd1);
        check("mrst_busy", {31'd0, busy_o}, 32'd0);
        check("mrst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk_i); rst_i = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o) done_seen = 1'b1;
        end
        check("mrst_no_done", {31'd0, done_seen}, 32'd0);
        single("post_rst", 4'b0010, 32'd2, 32'd2, 5'd0, 32'd4, 1'b0);

`ifdef ALU_ITER_MUL_EN
        check("busy_seen", {31'd0, busy_seen}, 32'd1);
`else
        check("busy_never", {31'd0, busy_seen}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
